// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle controller, its decode sub-block and
// anything that talks to it (datapath, bench):
//   state_t        FSM state encoding (also visible on the debug state output)
//   OP_*           instruction[31:26] opcodes understood by the controller
//   ALU_*          alu_op codes
//   PC_SRC_*       pc_src mux codes
//   dec_t          per-opcode control bundle produced by ctrl_decode
//   WAIT_CNT_W     width of the memory wait counter
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam int WAIT_CNT_W = 4;

    // Everything the FSM needs to know about the latched instruction.
    typedef struct packed {
        logic       legal;      // opcode is one of the six supported ones
        logic       is_branch;  // beq: conditional PC load in EXEC
        logic       is_jump;    // j: unconditional PC load in EXEC
        logic       has_mem;    // lw/sw: visits MEM after EXEC
        logic       mem_write;  // sw: MEM writes instead of reads
        logic       has_wb;     // R/lw/addi: visits WB
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       mem2reg;
    } dec_t;

    // States that own a memory access and therefore run the wait counter.
    function automatic logic is_access_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle controller and its datapath/memory.
//   slave  modport: the controller (takes opcode/zero/mem_ready, drives controls)
//   master modport: the datapath side (drives opcode/zero/mem_ready)
// Signals:
//   opcode[5:0], zero, mem_ready            -> controller
//   IorD, MemRead, MemWrite, ir_write,
//   pc_write, pc_src[1:0], RegDst, ALUSrc,
//   RegWrite, Mem2Reg, alu_op[1:0], fault,
//   state[2:0]                              <- controller
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       RegDst;
    logic       ALUSrc;
    logic       RegWrite;
    logic       Mem2Reg;
    logic [1:0] alu_op;
    logic       fault;
    logic [2:0] state;

    modport slave (
        input  opcode, zero, mem_ready,
        output IorD, MemRead, MemWrite, ir_write, pc_write, pc_src,
               RegDst, ALUSrc, RegWrite, Mem2Reg, alu_op, fault, state
    );

    modport master (
        output opcode, zero, mem_ready,
        input  IorD, MemRead, MemWrite, ir_write, pc_write, pc_src,
               RegDst, ALUSrc, RegWrite, Mem2Reg, alu_op, fault, state
    );
endinterface

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Pure combinational opcode-to-control decode for the multicycle controller.
//   i_opcode[5:0]  latched instruction[31:26]
//   o_dec          control bundle (dec_t); all-zero (legal=0) for unknown
//                  opcodes
// ---------------------------------------------------------------------------
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_RTYPE: begin
                o_dec.legal   = 1'b1;
                o_dec.alu_op  = ALU_FUNCT;
                o_dec.has_wb  = 1'b1;
                o_dec.reg_dst = 1'b1;
            end
            OP_LW: begin
                o_dec.legal   = 1'b1;
                o_dec.alu_op  = ALU_ADD;
                o_dec.alu_src = 1'b1;
                o_dec.has_mem = 1'b1;
                o_dec.has_wb  = 1'b1;
                o_dec.mem2reg = 1'b1;
            end
            OP_SW: begin
                o_dec.legal     = 1'b1;
                o_dec.alu_op    = ALU_ADD;
                o_dec.alu_src   = 1'b1;
                o_dec.has_mem   = 1'b1;
                o_dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                o_dec.legal     = 1'b1;
                o_dec.alu_op    = ALU_SUB;
                o_dec.is_branch = 1'b1;
            end
            OP_ADDI: begin
                o_dec.legal   = 1'b1;
                o_dec.alu_op  = ALU_ADD;
                o_dec.alu_src = 1'b1;
                o_dec.has_wb  = 1'b1;
            end
            OP_J: begin
                o_dec.legal   = 1'b1;
                o_dec.is_jump = 1'b1;
            end
            default: o_dec = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle MIPS-style datapath,
// with a memory wait-state timeout and a sticky FAULT state.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    multicycle_ctrl_if.slave (opcode/zero/mem_ready in, controls out)
// Parameter MEM_TIMEOUT: wait cycles tolerated per memory access before a
// bus fault; must fit in WAIT_CNT_W bits.
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_ctrl_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_t                r_state;
    state_t                w_state_next;
    logic [5:0]            r_opcode;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic                  r_started;
    logic                  w_timeout;
    dec_t                  w_dec;

    ctrl_decode u_ctrl_decode (
        .i_opcode (r_opcode),
        .o_dec    (w_dec)
    );

    // r_wait_cnt counts the wait cycles already spent on the current access.
    // The cycle in which it equals TIMEOUT_CNT is the last chance: mem_ready
    // there still completes the access, otherwise we fault.
    assign w_timeout = (r_wait_cnt == TIMEOUT_CNT) && !bus.mem_ready;

    // r_started is low from reset until the first clock edge after release,
    // so an access interrupted by reset is not re-issued while rst_n is low
    // and the fresh FETCH begins on that first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_opcode   <= '0;
            r_wait_cnt <= '0;
            r_started  <= 1'b0;
        end else begin
            r_started  <= 1'b1;
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (r_started && (r_state == ST_FETCH) && bus.mem_ready) begin
                r_opcode <= bus.opcode;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (r_started) begin
                    if (bus.mem_ready) begin
                        w_state_next = ST_DECODE;
                    end else if (w_timeout) begin
                        w_state_next = ST_FAULT;
                    end
                end
            end
            ST_DECODE: w_state_next = w_dec.legal ? ST_EXEC : ST_FAULT;
            ST_EXEC: begin
                if (w_dec.has_mem) begin
                    w_state_next = ST_MEM;
                end else if (w_dec.has_wb) begin
                    w_state_next = ST_WB;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    w_state_next = w_dec.has_wb ? ST_WB : ST_FETCH;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_WB:    w_state_next = ST_FETCH;
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_FAULT;
        endcase

        // Counting only while we stay in an access state also clears the
        // counter on every entry into FETCH or MEM.
        if (r_started && is_access_state(r_state) && (w_state_next == r_state)) begin
            w_wait_cnt_next = r_wait_cnt + WAIT_CNT_W'(1);
        end else begin
            w_wait_cnt_next = '0;
        end
    end

    // Outputs follow the state and latched opcode; the two exceptions are the
    // fetch-completion pulse (qualified by mem_ready) and the beq PC load
    // (qualified by zero).
    always_comb begin
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_src   = PC_SRC_SEQ;
        bus.RegDst   = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.Mem2Reg  = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.fault    = 1'b0;
        bus.state    = r_state;
        case (r_state)
            ST_FETCH: begin
                bus.MemRead  = r_started;
                bus.ir_write = r_started && bus.mem_ready;
                bus.pc_write = r_started && bus.mem_ready;
                bus.pc_src   = PC_SRC_SEQ;
            end
            ST_EXEC: begin
                bus.alu_op = w_dec.alu_op;
                bus.ALUSrc = w_dec.alu_src;
                if (w_dec.is_branch) begin
                    bus.pc_src   = PC_SRC_BRANCH;
                    bus.pc_write = bus.zero;
                end
                if (w_dec.is_jump) begin
                    bus.pc_src   = PC_SRC_JUMP;
                    bus.pc_write = 1'b1;
                end
            end
            ST_MEM: begin
                bus.IorD     = 1'b1;
                bus.MemRead  = !w_dec.mem_write;
                bus.MemWrite = w_dec.mem_write;
            end
            ST_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = w_dec.reg_dst;
                bus.Mem2Reg  = w_dec.mem2reg;
            end
            ST_FAULT: bus.fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Table of instructions driven back to back, plus hand sequences for the
// illegal opcode, FETCH timeout and reset-in-MEM corners. Every cycle pushes
// its expected outputs (value + mask of specified bits) to a scoreboard queue
// and pops/compares them half a clock later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] state;
        logic       fault;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       regwrite;
        logic       regdst;
        logic       mem2reg;
        logic       alusrc;
        logic [1:0] alu_op;
    } obs_t;

    typedef struct {
        obs_t  exp;
        obs_t  mask;
        string name;
    } sb_t;

    typedef struct {
        string      name;
        logic [5:0] opcode;
        logic       zero;
        int         fwait;
        int         mwait;
        logic [1:0] alu_op;
        logic       alusrc;
        logic       chk_alu;
        logic       ex_pcw;
        logic [1:0] ex_pcsrc;
        logic       has_mem;
        logic       mem_wr;
        logic       has_wb;
        logic       regdst;
        logic       mem2reg;
    } vec_t;

    sb_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[11];

    function automatic obs_t sample();
        obs_t o;
        o.state    = bus.state;
        o.fault    = bus.fault;
        o.iord     = bus.IorD;
        o.memread  = bus.MemRead;
        o.memwrite = bus.MemWrite;
        o.ir_write = bus.ir_write;
        o.pc_write = bus.pc_write;
        o.pc_src   = bus.pc_src;
        o.regwrite = bus.RegWrite;
        o.regdst   = bus.RegDst;
        o.mem2reg  = bus.Mem2Reg;
        o.alusrc   = bus.ALUSrc;
        o.alu_op   = bus.alu_op;
        return o;
    endfunction

    // State, fault and all write/request strobes are defined in every state.
    function automatic obs_t base_mask();
        obs_t m = '0;
        m.state    = '1;
        m.fault    = 1'b1;
        m.memread  = 1'b1;
        m.memwrite = 1'b1;
        m.ir_write = 1'b1;
        m.pc_write = 1'b1;
        m.regwrite = 1'b1;
        return m;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_head();
        sb_t e;
        obs_t act;
        logic [$bits(obs_t)-1:0] diff;
        e    = sb_q.pop_front();
        act  = sample();
        diff = (act ^ e.exp) & e.mask;
        checks++;
        if (diff !== '0) begin
            failures++;
            $display("FAIL %s: got=%05h expected=%05h (mask %05h)",
                     e.name, act, e.exp, e.mask);
        end
    endtask

    task automatic check_now(input obs_t exp, input obs_t mask, input string name);
        sb_t e;
        e.exp = exp; e.mask = mask; e.name = name;
        sb_q.push_back(e);
        check_head();
    endtask

    // One clock: drive inputs just after the edge, compare at the falling edge.
    task automatic cycle(input logic mr, input logic z, input logic scr,
                         input obs_t exp, input obs_t mask, input string name);
        sb_t e;
        @(posedge clk);
        #1;
        bus.mem_ready = mr;
        bus.zero      = z;
        if (scr) bus.opcode = 6'($urandom);
        e.exp = exp; e.mask = mask; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        check_head();
    endtask

    function automatic obs_t fetch_exp(input logic done);
        obs_t e = '0;
        e.state   = ST_FETCH;
        e.memread = 1'b1;
        if (done) begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
            e.pc_src   = PC_SRC_SEQ;
        end
        return e;
    endfunction

    function automatic obs_t fetch_mask(input logic done);
        obs_t m = base_mask();
        m.iord = 1'b1;
        if (done) m.pc_src = '1;
        return m;
    endfunction

    function automatic obs_t state_exp(input state_t s);
        obs_t e = '0;
        e.state = s;
        e.fault = (s == ST_FAULT);
        return e;
    endfunction

    task automatic issue(input vec_t v);
        obs_t e, m;
        bus.opcode = v.opcode;
        for (int i = 0; i <= v.fwait; i++) begin
            cycle(i == v.fwait, rbit(), 1'b0, fetch_exp(i == v.fwait),
                  fetch_mask(i == v.fwait), $sformatf("%s fetch%0d", v.name, i));
        end
        cycle(rbit(), rbit(), 1'b1, state_exp(ST_DECODE), base_mask(),
              $sformatf("%s decode", v.name));
        e = state_exp(ST_EXEC);
        m = base_mask();
        if (v.chk_alu) begin
            e.alu_op = v.alu_op; e.alusrc = v.alusrc;
            m.alu_op = '1;       m.alusrc = 1'b1;
        end
        e.pc_write = v.ex_pcw;
        if (v.ex_pcw) begin
            e.pc_src = v.ex_pcsrc; m.pc_src = '1;
        end
        cycle(rbit(), v.zero, 1'b1, e, m, $sformatf("%s exec", v.name));
        if (v.has_mem) begin
            for (int i = 0; i <= v.mwait; i++) begin
                e = state_exp(ST_MEM);
                e.iord = 1'b1; e.memread = !v.mem_wr; e.memwrite = v.mem_wr;
                m = base_mask(); m.iord = 1'b1;
                cycle(i == v.mwait, rbit(), 1'b1, e, m, $sformatf("%s mem%0d", v.name, i));
            end
        end
        if (v.has_wb) begin
            e = state_exp(ST_WB);
            e.regwrite = 1'b1; e.regdst = v.regdst; e.mem2reg = v.mem2reg;
            m = base_mask(); m.regdst = 1'b1; m.mem2reg = 1'b1;
            cycle(rbit(), rbit(), 1'b1, e, m, $sformatf("%s wb", v.name));
        end
        $display("instr %-8s opcode=%02h fwait=%0d mwait=%0d checks=%0d failures=%0d",
                 v.name, v.opcode, v.fwait, v.mwait, checks, failures);
    endtask

    // Asynchronous reset between clock edges; outputs must react immediately.
    task automatic apply_reset(input string name);
        obs_t m;
        m = '0;
        m.state = '1; m.fault = 1'b1; m.memwrite = 1'b1; m.regwrite = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now(state_exp(ST_FETCH), m, name);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset %s checks=%0d failures=%0d", name, checks, failures);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e, m;
        //           name        opcode    zero  fw  mw  alu_op     src   chk   pcw   pcsrc          mem   wr    wb    rdst  m2r
        vecs[0]  = '{"add",     OP_RTYPE, 1'b0, 0,  0,  ALU_FUNCT, 1'b0, 1'b1, 1'b0, PC_SRC_SEQ,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{"lw_w2",   OP_LW,    1'b0, 0,  2,  ALU_ADD,   1'b1, 1'b1, 1'b0, PC_SRC_SEQ,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{"sw",      OP_SW,    1'b0, 0,  0,  ALU_ADD,   1'b1, 1'b1, 1'b0, PC_SRC_SEQ,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"beq_t",   OP_BEQ,   1'b1, 0,  0,  ALU_SUB,   1'b0, 1'b1, 1'b1, PC_SRC_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"beq_nt",  OP_BEQ,   1'b0, 0,  0,  ALU_SUB,   1'b0, 1'b1, 1'b0, PC_SRC_SEQ,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"addi",    OP_ADDI,  1'b0, 0,  0,  ALU_ADD,   1'b1, 1'b1, 1'b0, PC_SRC_SEQ,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"j",       OP_J,     1'b0, 0,  0,  ALU_ADD,   1'b0, 1'b0, 1'b1, PC_SRC_JUMP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"add_f3",  OP_RTYPE, 1'b1, 3,  0,  ALU_FUNCT, 1'b0, 1'b1, 1'b0, PC_SRC_SEQ,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"sw_m15",  OP_SW,    1'b1, 1,  15, ALU_ADD,   1'b1, 1'b1, 1'b0, PC_SRC_SEQ,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"j_f15",   OP_J,     1'b1, 15, 0,  ALU_ADD,   1'b0, 1'b0, 1'b1, PC_SRC_JUMP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"lw_f2m1", OP_LW,    1'b1, 2,  1,  ALU_ADD,   1'b1, 1'b1, 1'b0, PC_SRC_SEQ,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Power-on reset state.
        repeat (2) @(negedge clk);
        m = '0; m.state = '1; m.fault = 1'b1; m.memwrite = 1'b1; m.regwrite = 1'b1;
        check_now(state_exp(ST_FETCH), m, "por_state");
        rst_n = 1'b1;

        foreach (vecs[i]) issue(vecs[i]);

        // Illegal opcode: FAULT after DECODE, absorbing for 20+ cycles.
        bus.opcode = 6'h3F;
        cycle(1'b1, rbit(), 1'b0, fetch_exp(1'b1), fetch_mask(1'b1), "illegal fetch");
        cycle(rbit(), rbit(), 1'b1, state_exp(ST_DECODE), base_mask(), "illegal decode");
        for (int i = 0; i < 21; i++) begin
            cycle(rbit(), rbit(), 1'b1, state_exp(ST_FAULT), base_mask(),
                  $sformatf("illegal fault%0d", i));
        end
        apply_reset("clear_illegal");
        issue(vecs[0]);

        // FETCH timeout: 15 wait cycles bring the counter to the limit, the
        // next low cycle at the limit faults.
        bus.opcode = OP_ADDI;
        for (int i = 0; i <= 15; i++) begin
            cycle(1'b0, rbit(), 1'b0, fetch_exp(1'b0), fetch_mask(1'b0),
                  $sformatf("timeout wait%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(rbit(), rbit(), 1'b0, state_exp(ST_FAULT), base_mask(),
                  $sformatf("timeout fault%0d", i));
        end
        apply_reset("clear_timeout");

        // Reset while sw is waiting in MEM: MemWrite must drop with no edge.
        bus.opcode = OP_SW;
        cycle(1'b1, rbit(), 1'b0, fetch_exp(1'b1), fetch_mask(1'b1), "rstmem fetch");
        cycle(rbit(), rbit(), 1'b1, state_exp(ST_DECODE), base_mask(), "rstmem decode");
        cycle(rbit(), rbit(), 1'b1, state_exp(ST_EXEC), base_mask(), "rstmem exec");
        for (int i = 0; i < 2; i++) begin
            e = state_exp(ST_MEM); e.iord = 1'b1; e.memwrite = 1'b1;
            m = base_mask(); m.iord = 1'b1;
            cycle(1'b0, rbit(), 1'b1, e, m, $sformatf("rstmem mem%0d", i));
        end
        apply_reset("abandon_sw");
        issue(vecs[1]);
        issue(vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
